dcache_responder: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers load/store requests from the memory stage. It replaces the combinational data memory at the memory stage and drives a word-wide backing-memory port. Hits return read data combinationally with no stall. Misses and all stores assert stall while the cache talks to backing memory.

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_load_align.sv | 63 ++++++
 rtl/dcache_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_dcache_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the data cache responder.
package dcache_pkg;

    // Access size, encoded as the RISC-V funct3 of the load/store.
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        RESP
    } state_t;

    // Byte-offset bits within a data word.
    function automatic int unsigned offset_bits(int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Word-select bits within a line.
    function automatic int unsigned word_bits(int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Set-index bits.
    function automatic int unsigned index_bits(int unsigned sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_load_align.sv
// Lane steering for the data cache: extracts and extends load data from a cached word,
// and replicates store data onto its byte lanes with the matching write strobe.
// Byte lanes assume a 32-bit word (4-bit strobe).
module dcache_load_align
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            offset_i,
    input  logic [2:0]            size_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [DATA_WIDTH-1:0] lane_data_o,
    output logic [3:0]            strobe_o,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;

    assign shifted = word_i >> {offset_i, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = shifted[15:0];

    // Decode size into load extension, store lanes/strobe and alignment check.
    always_comb begin
        rdata_o     = word_i;
        lane_data_o = wdata_i;
        strobe_o    = 4'b1111;
        misalign_o  = 1'b0;
        case (size_t'(size_i))
            SZ_B: begin
                rdata_o     = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
                lane_data_o = {(DATA_WIDTH/8){wdata_i[7:0]}};
                strobe_o    = 4'b0001 << offset_i;
            end
            SZ_BU: begin
                rdata_o     = {{(DATA_WIDTH-8){1'b0}}, byte_v};
                lane_data_o = {(DATA_WIDTH/8){wdata_i[7:0]}};
                strobe_o    = 4'b0001 << offset_i;
            end
            SZ_H: begin
                rdata_o     = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
                lane_data_o = {(DATA_WIDTH/16){wdata_i[15:0]}};
                strobe_o    = 4'b0011 << offset_i;
                misalign_o  = offset_i[0];
            end
            SZ_HU: begin
                rdata_o     = {{(DATA_WIDTH-16){1'b0}}, half_v};
                lane_data_o = {(DATA_WIDTH/16){wdata_i[15:0]}};
                strobe_o    = 4'b0011 << offset_i;
                misalign_o  = offset_i[0];
            end
            default: begin
                // Word access (and unused encodings treated as word).
                misalign_o = |offset_i;
            end
        endcase
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Hits answer combinationally; misses refill a whole line in beat order, stores always
// write through to backing memory and update the line only on a hit.
// Optional: define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_size,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  misalign,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int unsigned OffW  = offset_bits(DATA_WIDTH);
    localparam int unsigned WordW = word_bits(LINE_WORDS);
    localparam int unsigned IdxW  = index_bits(SETS);
    localparam int unsigned TagW  = ADDR_WIDTH - OffW - WordW - IdxW;

    logic [1:0]       req_off;
    logic [WordW-1:0] req_word;
    logic [IdxW-1:0]  req_idx;
    logic [TagW-1:0]  req_tag;

    assign req_off  = req_addr[1:0];
    assign req_word = req_addr[OffW +: WordW];
    assign req_idx  = req_addr[OffW+WordW +: IdxW];
    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TagW];

    // Line storage: data and tags carry no reset, the valid bits guard them.
    logic [DATA_WIDTH-1:0] data_mem [SETS*LINE_WORDS];
    logic [TagW-1:0]       tag_mem  [SETS];
    logic [SETS-1:0]       valid_q, valid_d;

    state_t            state_q, state_d;
    logic [WordW-1:0]  beat_q, beat_d;

    logic                    data_we;
    logic [IdxW+WordW-1:0]   data_waddr;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic                    tag_we;

    logic [DATA_WIDTH-1:0] line_word;
    logic                  hit;
    logic [DATA_WIDTH-1:0] ld_rdata;
    logic [DATA_WIDTH-1:0] st_lane;
    logic [3:0]            st_strb;
    logic                  ld_mis;
    logic [DATA_WIDTH-1:0] merged;

    assign line_word = data_mem[{req_idx, req_word}];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    dcache_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .word_i      (line_word),
        .offset_i    (req_off),
        .size_i      (req_size),
        .wdata_i     (req_wdata),
        .rdata_o     (ld_rdata),
        .lane_data_o (st_lane),
        .strobe_o    (st_strb),
        .misalign_o  (ld_mis)
    );

    // Byte-merge of a store hit into the cached word.
    always_comb begin
        merged = line_word;
        for (int i = 0; i < 4; i++) begin
            if (st_strb[i]) begin
                merged[8*i +: 8] = st_lane[8*i +: 8];
            end
        end
    end

    // Next state, array writes and all outputs; outputs are forced low while in reset.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        valid_d       = valid_q;
        data_we       = 1'b0;
        data_waddr    = {req_idx, beat_q};
        data_wdata    = mem_rdata;
        tag_we        = 1'b0;
        rdata         = '0;
        stall         = 1'b0;
        misalign      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (ld_mis) begin
                        misalign = 1'b1;
                    end else if (req_write) begin
                        stall   = 1'b1;
                        state_d = WRITE;
                    end else if (hit) begin
                        rdata = ld_rdata;
                    end else begin
                        stall   = 1'b1;
                        state_d = REFILL;
                        beat_d  = '0;
                        // Line is being overwritten; keep it invalid until the last beat.
                        valid_d[req_idx] = 1'b0;
                    end
                end
            end
            REFILL: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_addr      = {req_tag, req_idx, beat_q, {OffW{1'b0}}};
                if (mem_ready) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, beat_q};
                    data_wdata = mem_rdata;
                    beat_d     = beat_q + 1'b1;
                    if (beat_q == WordW'(LINE_WORDS - 1)) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        state_d          = RESP;
                    end
                end
            end
            WRITE: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_addr      = {req_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
                mem_wdata     = st_lane;
                mem_wstrb     = st_strb;
                if (mem_ready) begin
                    if (hit) begin
                        data_we    = 1'b1;
                        data_waddr = {req_idx, req_word};
                        data_wdata = merged;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!req_write) begin
                    rdata = ld_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            data_we       = 1'b0;
            tag_we        = 1'b0;
            rdata         = '0;
            stall         = 1'b0;
            misalign      = 1'b0;
            mem_req_valid = 1'b0;
            mem_req_write = 1'b0;
            mem_addr      = '0;
            mem_wdata     = '0;
            mem_wstrb     = 4'b0000;
        end
    end

    // Controller state and valid bits; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    // Line data and tag arrays.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        hit_evt, miss_evt;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    assign hit_evt  = (state_q == IDLE) && req_valid && !req_write && !ld_mis && hit;
    assign miss_evt = (state_q == IDLE) && req_valid && !req_write && !ld_mis && !hit;

    // Saturating load hit/miss counters.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_evt && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_evt && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: stimulus pushes expected retirements and
// backing-memory writes; a negedge monitor pops and compares them.
module tb_dcache_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_size      (req_size),
        .rdata         (rdata),
        .stall         (stall),
        .misalign      (misalign),
        .mem_req_valid (mem_req_valid),
        .mem_req_write (mem_req_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    typedef struct {
        bit          is_load;
        bit          misal;
        logic [31:0] rdata;
        int          beats;
        int          writes;
        int          stall_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt;
    logic [31:0] bmem [0:1023];

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Backing memory: ready after lat wait cycles, reads combinational, strobed writes.
    assign mem_ready = mem_req_valid && (wait_cnt >= lat);
    assign mem_rdata = bmem[mem_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) bmem[i] <= 32'h0;
        bmem[32'h100 >> 2] <= 32'h11111111;
        bmem[32'h104 >> 2] <= 32'h22222222;
        bmem[32'h108 >> 2] <= 32'h000080F0;
        bmem[32'h10C >> 2] <= 32'h44444444;
        bmem[32'h500 >> 2] <= 32'h55555555;
        wait_cnt <= 0;
        forever begin
            @(posedge clk);
            if (mem_req_valid && mem_ready && mem_req_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) bmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            if (mem_req_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
        end
    end

    // Monitor: count beats/writes/stall cycles and compare on each retirement.
    initial begin
        int   beats;
        int   writes;
        int   stall_cyc;
        exp_t e;
        wr_t  w;
        beats = 0;
        writes = 0;
        stall_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                beats = 0;
                writes = 0;
                stall_cyc = 0;
            end else begin
                if (mem_req_valid && mem_ready) begin
                    if (mem_req_write) begin
                        writes++;
                        if (wr_q.size() == 0) begin
                            fail("unexpected_mem_write");
                        end else begin
                            w = wr_q.pop_front();
                            chk("wr_addr", mem_addr, w.addr);
                            chk("wr_data", mem_wdata, w.wdata);
                            chk("wr_strb", {28'h0, mem_wstrb}, {28'h0, w.strb});
                        end
                    end else begin
                        beats++;
                    end
                end
                if (req_valid && stall) stall_cyc++;
                if (req_valid && !stall) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_retire");
                    end else begin
                        e = exp_q.pop_front();
                        chk("misalign", {31'h0, misalign}, {31'h0, e.misal});
                        if (e.is_load || e.misal) chk("rdata", rdata, e.rdata);
                        chk("refill_beats", 32'(beats), 32'(e.beats));
                        chk("mem_writes", 32'(writes), 32'(e.writes));
                        chk("stall_cycles", 32'(stall_cyc), 32'(e.stall_cyc));
                    end
                    beats = 0;
                    writes = 0;
                    stall_cyc = 0;
                end
            end
        end
    end

    task automatic issue(input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input bit em,
                         input int eb, input int ew, input int es);
        exp_t e;
        int   n;
        e.is_load = !wr;
        e.misal = em;
        e.rdata = er;
        e.beats = eb;
        e.writes = ew;
        e.stall_cyc = es;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_size = sz;
        req_addr = addr;
        req_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) fail("stall_timeout");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic load_hit(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] er);
        issue(1'b0, sz, addr, 32'h0, er, 1'b0, 0, 0, 0);
    endtask

    task automatic load_miss(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] er);
        issue(1'b0, sz, addr, 32'h0, er, 1'b0, 4, 0, 1 + 4 * (1 + lat));
    endtask

    task automatic store(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] waddr, input logic [31:0] wlane, input logic [3:0] strb);
        wr_t w;
        w.addr = waddr;
        w.wdata = wlane;
        w.strb = strb;
        wr_q.push_back(w);
        issue(1'b1, sz, addr, wd, 32'h0, 1'b0, 0, 1, 2 + lat);
    endtask

    task automatic mis(input bit wr, input logic [2:0] sz, input logic [31:0] addr);
        issue(wr, sz, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0, 0);
    endtask

    task automatic check_outputs_clear(input string tag);
        chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
        chk({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
        chk({tag, "_mem_req_valid"}, {31'h0, mem_req_valid}, 32'h0);
        chk({tag, "_mem_req_write"}, {31'h0, mem_req_write}, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_wstrb"}, {28'h0, mem_wstrb}, 32'h0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_size = LW;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_clear("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Refill then hits across sizes and offsets.
        lat = 0;
        load_miss(LW, 32'h104, 32'h22222222);
        load_hit(LW, 32'h10C, 32'h44444444);
        load_hit(LB, 32'h10F, 32'h00000044);
        load_hit(LH, 32'h108, 32'hFFFF80F0);
        load_hit(LHU, 32'h108, 32'h000080F0);
        load_hit(LB, 32'h109, 32'hFFFFFF80);
        load_hit(LBU, 32'h109, 32'h00000080);
        load_hit(LH, 32'h10E, 32'h00004444);
        load_hit(LHU, 32'h10A, 32'h00000000);
        load_hit(LH, 32'h102, 32'h00001111);

        // Store hits write through and merge into the line.
        lat = 1;
        store(LB, 32'h105, 32'h123456AB, 32'h104, 32'hABABABAB, 4'b0010);
        load_hit(LW, 32'h104, 32'h2222AB22);
        store(LH, 32'h10A, 32'h0000BEEF, 32'h108, 32'hBEEFBEEF, 4'b1100);
        load_hit(LW, 32'h108, 32'hBEEF80F0);

        // Store miss does not allocate; the following load refills.
        store(LW, 32'h200, 32'hDEADBEEF, 32'h200, 32'hDEADBEEF, 4'b1111);
        lat = 2;
        load_miss(LW, 32'h200, 32'hDEADBEEF);
        load_hit(LH, 32'h202, 32'hFFFFDEAD);

        // Misaligned accesses: flagged, no stall, no memory traffic.
        mis(1'b0, LW, 32'h102);
        mis(1'b0, LH, 32'h101);
        mis(1'b0, LHU, 32'h103);
        mis(1'b1, LW, 32'h106);
        mis(1'b1, LH, 32'h109);

        // Conflict eviction on the same set.
        lat = 0;
        load_miss(LW, 32'h500, 32'h55555555);
        load_miss(LW, 32'h104, 32'h2222AB22);
        load_hit(LW, 32'h108, 32'hBEEF80F0);

        // Reset in the middle of a refill, at beat 2.
        load_miss(LW, 32'h500, 32'h55555555);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = LW;
        req_addr = 32'h104;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req_valid && mem_addr == 32'h108) && n < 50);
        if (n >= 50) fail("beat2_timeout");
        #1;
        rst = 1'b0;
        #1;
        check_outputs_clear("midreset");
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        load_miss(LW, 32'h104, 32'h2222AB22);
        load_miss(LW, 32'h500, 32'h55555555);

        repeat (3) @(posedge clk);
        chk("pending_retirements", 32'(exp_q.size()), 32'h0);
        chk("pending_writes", 32'(wr_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
